// File: rtl/mux_nx1_rr_pkg.sv
// Shared constants and helpers for the N-input round-robin output mux.
package mux_nx1_rr_pkg;

  // Arbitration mode encodings on the 'mode' input
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, used to size channel indices (value must be >= 2)
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Stream bundle between N producers, the mux and one consumer.
interface mux_nx1_rr_if
  import mux_nx1_rr_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) ();

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        select;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  // The mux itself: consumes producer streams and control, drives the output stream
  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  // The surrounding environment: producers, control and the consumer
  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/mux_nx1_rr_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after the last grant, wrapping.
module mux_nx1_rr_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

  logic [NUM_IN-1:0] masked;
  logic [NUM_IN-1:0] search;

  // Keep only requesters strictly above the last winner
  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      masked[i] = req[i] && (SEL_W'(i) > last);
    end
  end

  // Upper half wins if anything is there, otherwise wrap to the full request vector
  assign search    = (|masked) ? masked : req;
  assign any_grant = |req;

  // Lowest set bit of the chosen vector becomes the one-hot grant and its index
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (search[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-input valid/ready mux with one registered output stage, fixed or round-robin arbitration.
module mux_nx1_rr
  import mux_nx1_rr_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input logic         clk,
  input logic         rst_n,
  mux_nx1_rr_if.slave bus
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [NUM_IN-1:0] rr_onehot;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;
  logic [NUM_IN-1:0] fixed_onehot;
  logic [NUM_IN-1:0] grant_onehot;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              load_en;
  logic              transfer;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic              out_valid_q;

  mux_nx1_rr_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_arbiter (
    .req       (bus.in_valid),
    .last      (rr_ptr),
    .grant     (rr_onehot),
    .grant_idx (rr_idx),
    .any_grant (rr_any)
  );

  // Fixed mode grants only the selected channel; an out-of-range select matches nothing
  always_comb begin
    fixed_onehot = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      fixed_onehot[i] = bus.in_valid[i] && (bus.select == SEL_W'(i));
    end
  end

  // Choose between the fixed and round-robin grant for this cycle
  always_comb begin
    if (bus.mode == MODE_FIXED) begin
      grant_onehot = fixed_onehot;
      grant_valid  = |fixed_onehot;
      grant_idx    = bus.select;
    end else begin
      grant_onehot = rr_onehot;
      grant_valid  = rr_any;
      grant_idx    = rr_idx;
    end
  end

  // The output register accepts a word when empty or being drained this cycle
  assign load_en      = !out_valid_q || bus.out_ready;
  assign transfer     = rst_n && load_en && grant_valid;
  assign bus.in_ready = (rst_n && load_en) ? grant_onehot : '0;

  // Route the granted channel's data toward the output register
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: load on transfer, empty on drain without refill, hold on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_sel_q   <= grant_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Remember the last winner in both modes so a mode switch stays fair; reset favours ch0 next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= SEL_W'(NUM_IN - 1);
    end else if (transfer) begin
      rr_ptr <= grant_idx;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: directed vectors at NUM_IN=4/3 plus a scoreboard at 4 and 5.
module tb_mux_nx1_rr;
  import mux_nx1_rr_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [127:0] data4;

  bit   [4:0]  pend  [2];
  logic [31:0] pdata [2][5];
  logic [34:0] q0 [$];
  logic [34:0] q1 [$];
  int          seq = 0;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  mux_nx1_rr_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus4 ();
  mux_nx1_rr_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus3 ();
  mux_nx1_rr_if #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) bus5 ();

  mux_nx1_rr #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux_nx1_rr #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  mux_nx1_rr #(.WIDTH(32), .NUM_IN(5), .SEL_W(3)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [127:0] data, input logic mode,
                               input logic [1:0] select, input logic out_ready);
    bus4.in_valid  = valid;
    bus4.in_data   = data;
    bus4.mode      = mode;
    bus4.select    = select;
    bus4.out_ready = out_ready;
  endtask

  task automatic driveInst(input int k, input logic [4:0] v, input logic [159:0] d, input logic m,
                           input logic [2:0] s, input logic r);
    if (k == 0) begin
      applyStimulus(v[3:0], d[127:0], m, s[1:0], r);
    end else begin
      bus5.in_valid  = v;
      bus5.in_data   = d;
      bus5.mode      = m;
      bus5.select    = s;
      bus5.out_ready = r;
    end
  endtask

  task automatic sampleInst(input int k, output logic [4:0] rdy, output logic ov,
                            output logic [31:0] od, output logic [2:0] os);
    if (k == 0) begin
      rdy = {1'b0, bus4.in_ready};
      ov  = bus4.out_valid;
      od  = bus4.out_data;
      os  = {1'b0, bus4.out_sel};
    end else begin
      rdy = bus5.in_ready;
      ov  = bus5.out_valid;
      od  = bus5.out_data;
      os  = bus5.out_sel;
    end
  endtask

  // One random cycle on the 4- and 5-input DUTs; gen=0 stops new words and drains with RR
  task automatic randomCycle(input bit gen);
    logic        r_a [2];
    logic        m_a [2];
    logic [2:0]  s_a [2];
    logic [4:0]  v;
    logic [159:0] d;
    logic [4:0]  rdy;
    logic [4:0]  exp_rdy;
    logic        ov;
    logic        load;
    logic [31:0] od;
    logic [2:0]  os;
    logic [34:0] front;
    int          n;
    for (int k = 0; k < 2; k++) begin
      n      = (k == 0) ? 4 : 5;
      r_a[k] = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_a[k] = gen ? 1'($urandom_range(0, 1)) : MODE_RR;
      s_a[k] = 3'($urandom_range(0, (k == 0) ? 3 : 7));
      v = '0;
      d = '0;
      for (int ch = 0; ch < n; ch++) begin
        if (gen && !pend[k][ch] && ($urandom_range(0, 1) == 1)) begin
          pend[k][ch]  = 1'b1;
          pdata[k][ch] = {4'(k), 4'(ch), 24'(seq)};
          seq++;
        end
        v[ch]           = pend[k][ch];
        d[ch*32 +: 32]  = pdata[k][ch];
      end
      driveInst(k, v, d, m_a[k], s_a[k], r_a[k]);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 5;
      sampleInst(k, rdy, ov, od, os);
      load = !ov || r_a[k];
      if (ov && r_a[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          checkOutput("sb_extra_word", 1, 0);
        end else begin
          if (k == 0) front = q0.pop_front();
          else        front = q1.pop_front();
          checkOutput("sb_word", {29'd0, os, od}, {29'd0, front});
        end
      end
      if (m_a[k] == MODE_FIXED) begin
        exp_rdy = '0;
        if (load && (int'(s_a[k]) < n)) begin
          if (pend[k][s_a[k]]) exp_rdy[s_a[k]] = 1'b1;
        end
        checkOutput("fixed_ready", rdy, exp_rdy);
      end else begin
        checkOutput("rr_ready_any", rdy != 5'd0, load && (pend[k] != 5'd0));
        checkOutput("rr_ready_onehot", $countones(rdy) > 1, 0);
        checkOutput("rr_ready_valid", rdy & ~pend[k], 0);
      end
      for (int ch = 0; ch < n; ch++) begin
        if (rdy[ch] && pend[k][ch]) begin
          if (k == 0) q0.push_back({3'(ch), pdata[k][ch]});
          else        q1.push_back({3'(ch), pdata[k][ch]});
          pend[k][ch] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  // Directed vectors followed by the randomized scoreboard run
  initial begin
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    int exp_skip [4] = '{1, 3, 1, 3};

    data4 = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    applyStimulus(4'hF, data4, MODE_RR, 2'd0, 1'b1);
    bus3.in_valid = '0; bus3.in_data = '0; bus3.mode = MODE_FIXED; bus3.select = '0; bus3.out_ready = 1'b1;
    driveInst(1, 5'd0, 160'd0, MODE_RR, 3'd0, 1'b1);

    // Reset held 3 cycles with every channel valid
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", bus4.out_valid, 0);
    checkOutput("rst_out_data", bus4.out_data, 0);
    checkOutput("rst_out_sel", bus4.out_sel, 0);
    checkOutput("rst_in_ready", bus4.in_ready, 0);

    // Release: first RR grant favours ch0, then 1,2,3,0,1 back to back
    rst_n = 1'b1;
    #1;
    checkOutput("rr_first_ready", bus4.in_ready, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rr_valid", bus4.out_valid, 1);
      checkOutput("rr_sel", bus4.out_sel, exp_seq[i]);
      checkOutput("rr_data", bus4.out_data, 32'hA000_0000 + exp_seq[i]);
    end

    // Fixed select of ch2
    data4[64 +: 32] = 32'hDEAD_BEEF;
    applyStimulus(4'hF, data4, MODE_FIXED, 2'd2, 1'b1);
    #1;
    checkOutput("fixed_ready", bus4.in_ready, 4'b0100);
    @(negedge clk);
    checkOutput("fixed_data", bus4.out_data, 32'hDEAD_BEEF);
    checkOutput("fixed_sel", bus4.out_sel, 2);

    // Fixed ch0 leaves the last-grant pointer at 0 for the skip test
    applyStimulus(4'hF, data4, MODE_FIXED, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("fixed0_sel", bus4.out_sel, 0);

    // Only ch1 and ch3 valid: search skips idle channels and wraps through ch0
    applyStimulus(4'b1010, data4, MODE_RR, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("skip_sel", bus4.out_sel, exp_skip[i]);
      checkOutput("skip_valid", bus4.out_valid, 1);
    end

    // Backpressure: word 5 held 4 cycles, then word 6 loads as 5 drains
    data4[0 +: 32] = 32'h0000_0005;
    applyStimulus(4'hF, data4, MODE_FIXED, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("bp_load", bus4.out_data, 5);
    data4[0 +: 32] = 32'h0000_0006;
    applyStimulus(4'hF, data4, MODE_FIXED, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("bp_in_ready", bus4.in_ready, 0);
      @(negedge clk);
      checkOutput("bp_data", bus4.out_data, 5);
      checkOutput("bp_valid", bus4.out_valid, 1);
    end
    applyStimulus(4'hF, data4, MODE_FIXED, 2'd0, 1'b1);
    #1;
    checkOutput("bp_release_ready", bus4.in_ready, 4'b0001);
    @(negedge clk);
    checkOutput("bp_next_data", bus4.out_data, 6);
    checkOutput("bp_next_valid", bus4.out_valid, 1);

    // Nothing offered with consumer ready: valid drops, data and sel hold
    applyStimulus(4'h0, data4, MODE_RR, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("drain_valid", bus4.out_valid, 0);
    checkOutput("drain_data", bus4.out_data, 6);
    checkOutput("drain_sel", bus4.out_sel, 0);

    // NUM_IN=3: select=3 is out of range, no grant and the output empties
    bus3.in_valid = 3'b111;
    bus3.in_data  = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    bus3.mode     = MODE_FIXED;
    bus3.select   = 2'd1;
    @(negedge clk);
    checkOutput("n3_sel1", bus3.out_sel, 1);
    checkOutput("n3_data1", bus3.out_data, 32'hC000_0001);
    bus3.select = 2'd3;
    #1;
    checkOutput("n3_oor_ready", bus3.in_ready, 0);
    @(negedge clk);
    checkOutput("n3_oor_valid", bus3.out_valid, 0);
    checkOutput("n3_oor_sel", bus3.out_sel, 1);
    bus3.in_valid = '0;

    // Reset mid-stream clears the output immediately, between clock edges
    applyStimulus(4'hF, data4, MODE_RR, 2'd0, 1'b1);
    @(negedge clk);
    checkOutput("mid_pre_valid", bus4.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", bus4.out_valid, 0);
    checkOutput("mid_rst_data", bus4.out_data, 0);
    checkOutput("mid_rst_ready", bus4.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_after_ready", bus4.in_ready, 4'b0001);
    @(negedge clk);
    checkOutput("mid_after_sel", bus4.out_sel, 0);

    // Scoreboard run on NUM_IN=4 and NUM_IN=5 from a clean reset
    driveInst(0, 5'd0, 160'd0, MODE_RR, 3'd0, 1'b1);
    driveInst(1, 5'd0, 160'd0, MODE_RR, 3'd0, 1'b1);
    rst_n = 1'b0;
    pend[0] = '0;
    pend[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) randomCycle(1'b1);
    repeat (30) randomCycle(1'b0);
    checkOutput("sb_left_n4", q0.size(), 0);
    checkOutput("sb_left_n5", q1.size(), 0);
    checkOutput("sb_pend_n4", pend[0], 0);
    checkOutput("sb_pend_n5", pend[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
